// File: rtl/alu_task_pkg.sv
// Shared definitions for the registered 2-operand ALU: opcode encoding and default width.
package alu_task_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_SUB = 2'b10,
        OP_ADD = 2'b11
    } op_e;

endpackage

// File: rtl/alu_task_core.sv
// Stateless ALU datapath. The result is WIDTH+1 bits wide; the top bit carries the
// add carry-out or the subtract borrow.
module alu_task_core
    import alu_task_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [1:0]       code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   res
);

    op_e              w_op;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;

    assign w_op = op_e'(code);

    always_comb begin
        w_and = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_and[i] = a[i] & b[i];
        end
    end

    // Zero-extend both operands so the MSB of the difference is exactly the borrow.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res = '0;
        case (w_op)
            OP_AND:  res = {1'b0, w_and};
            OP_OR:   res = {1'b0, a | b};
            OP_SUB:  res = w_diff;
            OP_ADD:  res = w_sum;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_task_unit.sv
// Registered ALU leaf: one-cycle latency, result, valid and zero flag held in
// asynchronously reset registers.
module alu_task_unit
    import alu_task_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH:0]   c,
    output logic             zero
);

    logic [WIDTH:0] w_res;
    logic [WIDTH:0] r_c;
    logic           r_valid;
    logic           r_zero;

    alu_task_core #(.WIDTH(WIDTH)) u_core (
        .code (code),
        .a    (a),
        .b    (b),
        .res  (w_res)
    );

    // Handshake: in_valid qualifies code/a/b for one edge; there is no ready, so every
    // valid beat is accepted and out_valid pulses for exactly one cycle per accepted beat.
    // c and zero only update on accepted beats and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c     <= '0;
            r_valid <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_c    <= w_res;
                r_zero <= (w_res == '0);
            end
        end
    end

    assign c         = r_c;
    assign out_valid = r_valid;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu_task_unit.sv
// Bench for alu_task_unit: directed and random operations scored against an
// integer-arithmetic reference model through an expected-result queue.
module tb_alu_task_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [1:0]   code = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W:0]   c;
    logic         zero;

    logic [W:0]   exp_q[$];
    logic [W:0]   last_c = '0;
    logic         last_zero = 1'b1;
    int           checks = 0;
    int           errors = 0;
    bit           done = 1'b0;

    always #5 clk = ~clk;

    alu_task_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .code      (code),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .c         (c),
        .zero      (zero)
    );

    // Reference: plain integer arithmetic, result taken modulo 2^(W+1).
    function automatic logic [W:0] model(input int op, input int x, input int y);
        int m;
        int r;
        m = 1 << (W + 1);
        case (op)
            0:       r = x & y;
            1:       r = x | y;
            2:       r = (x - y + m) % m;
            default: r = x + y;
        endcase
        return r[W:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int op, input int x, input int y);
        code     = op[1:0];
        a        = x[W-1:0];
        b        = y[W-1:0];
        in_valid = 1'b1;
        @(posedge clk);
        if (rst_n) exp_q.push_back(model(op, x, y));
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        code     = 2'($urandom_range(0, 3));
        a        = W'($urandom_range(0, 15));
        b        = W'($urandom_range(0, 15));
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            issue($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, away from the active edge.
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (!rst_n) begin
                chk("rst_c", c, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_zero", zero, 1);
                last_c    = '0;
                last_zero = 1'b1;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("c", c, e);
                    chk("zero", zero, (e == '0));
                    last_c    = e;
                    last_zero = (e == '0);
                end
            end else begin
                chk("hold_c", c, last_c);
                chk("hold_zero", zero, last_zero);
            end
        end
    end

    initial begin
        int drain;
        // Reset held with live random traffic: nothing may be accepted.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            code = 2'($urandom_range(0, 3));
            a    = W'($urandom_range(0, 15));
            b    = W'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // Directed vectors, back to back.
        issue(0, 4'b0000, 4'b1111);
        issue(0, 4'b0111, 4'b1101);
        issue(1, 4'b0001, 4'b0011);
        issue(2, 4'b1001, 4'b0011);
        issue(2, 4'b0011, 4'b1001);
        issue(2, 4'b0101, 4'b0101);
        issue(3, 4'b0011, 4'b0001);
        issue(3, 4'b0111, 4'b1001);
        issue(3, 4'b1111, 4'b1111);
        idle(3);

        // Six back-to-back then hold.
        for (int i = 0; i < 6; i++)
            issue($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
        idle(3);

        random_ops(40);

        // Async reset between edges while a result is in flight.
        issue(3, 4'b0111, 4'b0110);
        issue(1, 4'b1010, 4'b0101);
        code     = 2'b11;
        a        = 4'b1111;
        b        = 4'b0001;
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_c", c, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_zero", zero, 1);
        exp_q.delete();
        last_c    = '0;
        last_zero = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        random_ops(20);
        idle(2);

        drain = 0;
        while (exp_q.size() != 0 && drain < 5) begin
            @(posedge clk);
            drain++;
        end
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
